// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1:N stream demultiplexer.
//   MODE_SELECT / MODE_ROUND_ROBIN : encodings of Mode_In
//   DROP_CNT_W                     : width of the discarded-beat counter
//   sat_inc()                      : saturating +1 for the drop counter
package demux_pkg;

    localparam logic MODE_SELECT      = 1'b0;
    localparam logic MODE_ROUND_ROBIN = 1'b1;

    localparam int unsigned DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/demux_hold_reg.sv
// Single-entry holding register {data, dest} with a full flag.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : capture data_i/dest_i and mark full (wins over drain_i)
//   drain_i   : held beat consumed this cycle; clears full unless reloaded
//   full_o    : entry holds a beat
//   data_o    : held data
//   dest_o    : held destination lane
module demux_hold_reg
    import demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [SEL_WIDTH-1:0]  dest_i,
    input  logic                  drain_i,
    output logic                  full_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [SEL_WIDTH-1:0]  dest_o
);

    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_WIDTH-1:0]  dest_q, dest_d;

    // Next-state: a same-cycle load replaces the draining beat
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        dest_d = dest_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
            dest_d = dest_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            dest_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            dest_q <= dest_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign dest_o = dest_q;

endmodule

// File: rtl/demux_1_n_stream.sv
// Registered 1:N valid/ready stream demultiplexer.
// Routes each accepted beat into a one-entry holding register tagged with its
// destination lane (explicit select or round-robin); beats addressed to a lane
// that does not exist are accepted and discarded, and counted.
//   Clock_In, Reset_In     : clock, asynchronous active-high reset
//   Enable_In              : 0 blocks new beats; a held beat may still drain
//   Mode_In, Select_In     : routing mode and explicit destination
//   Valid_In/Ready_Out     : input handshake (Ready_Out is combinational)
//   Data_In                : input beat
//   Valid_Out/Ready_In     : one-hot per-lane output handshake
//   Data_Out               : lane k at [k*DATA_WIDTH +: DATA_WIDTH], zero when idle
//   Drop_Pulse_Out         : one-cycle pulse per discarded beat
//   Drop_Count_Out         : saturating discarded-beat count
module demux_1_n_stream
    import demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned SEL_WIDTH    = 2
) (
    input  logic                             Clock_In,
    input  logic                             Reset_In,
    input  logic                             Enable_In,
    input  logic                             Mode_In,
    input  logic [SEL_WIDTH-1:0]             Select_In,
    input  logic                             Valid_In,
    output logic                             Ready_Out,
    input  logic [DATA_WIDTH-1:0]            Data_In,
    output logic [NUM_CHANNELS-1:0]          Valid_Out,
    input  logic [NUM_CHANNELS-1:0]          Ready_In,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_Out,
    output logic                             Drop_Pulse_Out,
    output logic [DROP_CNT_W-1:0]            Drop_Count_Out
);

    // Elaboration-time parameter sanity
    if (NUM_CHANNELS < 2) begin : g_bad_channels
        $error("demux_1_n_stream: NUM_CHANNELS must be >= 2");
    end
    if (SEL_WIDTH != $clog2(NUM_CHANNELS)) begin : g_bad_sel_width
        $error("demux_1_n_stream: SEL_WIDTH must equal $clog2(NUM_CHANNELS)");
    end

    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [SEL_WIDTH-1:0]  hold_dest;

    logic                  lane_ready;
    logic                  accept;
    logic [SEL_WIDTH-1:0]  dest;
    logic                  in_range;
    logic                  load;
    logic                  drain;

    logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  drop_pulse_q, drop_pulse_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Handshake, routing and next-state for pointer and drop bookkeeping
    always_comb begin
        lane_ready   = 1'b0;
        dest         = Select_In;
        rr_ptr_d     = rr_ptr_q;
        drop_cnt_d   = drop_cnt_q;

        // Loop-based lookup keeps the index in range for non-power-of-2 lane counts
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (hold_dest == SEL_WIDTH'(k)) begin
                lane_ready = Ready_In[k];
            end
        end

        Ready_Out = Enable_In & (~hold_full | lane_ready);
        accept    = Valid_In & Ready_Out;
        drain     = hold_full & lane_ready;

        if (Mode_In == MODE_ROUND_ROBIN) begin
            dest = rr_ptr_q;
        end
        in_range = (32'(dest) < NUM_CHANNELS);
        load     = accept & in_range;

        if (accept && (Mode_In == MODE_ROUND_ROBIN)) begin
            rr_ptr_d = (rr_ptr_q == SEL_WIDTH'(NUM_CHANNELS - 1)) ? '0
                                                                   : rr_ptr_q + SEL_WIDTH'(1);
        end

        drop_pulse_d = accept & ~in_range;
        if (drop_pulse_d) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            rr_ptr_q     <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    demux_hold_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_hold (
        .clk     (Clock_In),
        .rst     (Reset_In),
        .load_i  (load),
        .data_i  (Data_In),
        .dest_i  (dest),
        .drain_i (drain),
        .full_o  (hold_full),
        .data_o  (hold_data),
        .dest_o  (hold_dest)
    );

    // One-hot lane decode straight from the holding flops; idle lanes read zero
    always_comb begin
        Valid_Out = '0;
        Data_Out  = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (hold_full && (hold_dest == SEL_WIDTH'(k))) begin
                Valid_Out[k]                          = 1'b1;
                Data_Out[k*DATA_WIDTH +: DATA_WIDTH]  = hold_data;
            end
        end
    end

    assign Drop_Pulse_Out = drop_pulse_q;
    assign Drop_Count_Out = drop_cnt_q;

endmodule

// File: tb/tb_demux_1_n_stream.sv
module tb_demux_1_n_stream;

    logic clk;
    logic rst;

    // 4-lane instance
    logic        en4, mode4, vin4, rout4, dp4;
    logic [1:0]  sel4;
    logic [7:0]  din4, dc4;
    logic [3:0]  vout4, rin4;
    logic [31:0] dout4;

    // 3-lane instance (select value 3 is out of range)
    logic        en3, mode3, vin3, rout3, dp3;
    logic [1:0]  sel3;
    logic [7:0]  din3, dc3;
    logic [2:0]  vout3, rin3;
    logic [23:0] dout3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] rr_model = 2'd0;

    demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CHANNELS(4), .SEL_WIDTH(2)) dut4 (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en4), .Mode_In(mode4),
        .Select_In(sel4), .Valid_In(vin4), .Ready_Out(rout4), .Data_In(din4),
        .Valid_Out(vout4), .Ready_In(rin4), .Data_Out(dout4),
        .Drop_Pulse_Out(dp4), .Drop_Count_Out(dc4)
    );

    demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CHANNELS(3), .SEL_WIDTH(2)) dut3 (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en3), .Mode_In(mode3),
        .Select_In(sel3), .Valid_In(vin3), .Ready_Out(rout3), .Data_In(din3),
        .Valid_Out(vout3), .Ready_In(rin3), .Data_Out(dout3),
        .Drop_Pulse_Out(dp3), .Drop_Count_Out(dc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop on lane handshake, push on input accept (4-lane instance)
    task automatic sb_sample();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (vout4[k] && rin4[k]) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_lane", 64'(k), 64'(e.lane));
                    check("sb_data", 64'(dout4[k*8 +: 8]), 64'(e.data));
                end
            end
        end
        check("onehot", 64'($countones(vout4) <= 1), 64'd1);
        if (vin4 && rout4) begin
            e.lane = mode4 ? rr_model : sel4;
            e.data = din4;
            sb_q.push_back(e);
            if (mode4) rr_model = (rr_model == 2'd3) ? 2'd0 : rr_model + 2'd1;
        end
    endtask

    task automatic cycle();
        #1;
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en4 = 0; mode4 = 0; sel4 = 0; vin4 = 0; din4 = 0; rin4 = 0;
        en3 = 0; mode3 = 0; sel3 = 0; vin3 = 0; din3 = 0; rin3 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(vout4), 64'd0);
        check("rst_data", 64'(dout4), 64'd0);
        check("rst_pulse", 64'(dp4), 64'd0);
        check("rst_count", 64'(dc4), 64'd0);
        rst = 1'b0;
        en4 = 1'b1;

        // Select mode, lane 2
        mode4 = 0; sel4 = 2'd2; din4 = 8'hA5; vin4 = 1; rin4 = 4'b1111;
        #1;
        check("t1_ready", 64'(rout4), 64'd1);
        cycle();
        vin4 = 0;
        #1;
        check("t1_valid", 64'(vout4), 64'b0100);
        check("t1_data", 64'(dout4), 64'h00A5_0000);
        cycle();
        check("t1_empty", 64'(vout4), 64'd0);

        // Round-robin, 6 back-to-back beats
        mode4 = 1; rin4 = 4'b1111;
        for (int i = 1; i <= 6; i++) begin
            din4 = 8'(i); vin4 = 1;
            #1;
            check("t2_ready", 64'(rout4), 64'd1);
            cycle();
            check("t2_lane", 64'(vout4), 64'(4'b0001 << ((i - 1) % 4)));
        end
        vin4 = 0;
        cycle();
        check("t2_empty", 64'(vout4), 64'd0);

        // Back-pressure on lane 1 for 3 cycles; routing inputs wiggle meanwhile
        mode4 = 0; sel4 = 2'd1; din4 = 8'h3C; vin4 = 1; rin4 = 4'b1101;
        cycle();
        din4 = 8'h77;
        for (int j = 0; j < 3; j++) begin
            sel4 = 2'(j + 2); mode4 = 1'(j % 2);
            #1;
            check("t3_ready_low", 64'(rout4), 64'd0);
            check("t3_valid", 64'(vout4), 64'b0010);
            check("t3_data", 64'(dout4), 64'h0000_3C00);
            cycle();
        end
        mode4 = 0; sel4 = 2'd0; rin4 = 4'b1111;
        #1;
        check("t3_ready_drain", 64'(rout4), 64'd1);
        cycle();
        check("t3_replace_valid", 64'(vout4), 64'b0001);
        check("t3_replace_data", 64'(dout4), 64'h0000_0077);
        vin4 = 0;
        cycle();

        // Enable dropped while lane 3 holds a beat
        mode4 = 0; sel4 = 2'd3; din4 = 8'h5A; vin4 = 1; rin4 = 4'b0111;
        cycle();
        en4 = 0; din4 = 8'h66;
        #1;
        check("t5_ready_dis", 64'(rout4), 64'd0);
        check("t5_held", 64'(vout4), 64'b1000);
        cycle();
        rin4 = 4'b1111;
        #1;
        check("t5_ready_dis2", 64'(rout4), 64'd0);
        cycle();
        check("t5_drained", 64'(vout4), 64'd0);
        check("t5_no_accept", 64'(sb_q.size()), 64'd0);

        // Round-robin pointer is at 2 after six RR beats; hold then reset
        en4 = 1; mode4 = 1; din4 = 8'h11; vin4 = 1; rin4 = 4'b1011;
        cycle();
        check("t5_rr_held", 64'(vout4), 64'b0100);
        vin4 = 0;
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_valid", 64'(vout4), 64'd0);
        check("t5_async_data", 64'(dout4), 64'd0);
        sb_q.delete();
        rr_model = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mode4 = 1; din4 = 8'h22; vin4 = 1; rin4 = 4'b1111;
        cycle();
        check("t5_rr_reset", 64'(vout4), 64'b0001);
        vin4 = 0;
        cycle();
        check("t4_no_drop_4lane", 64'(dc4), 64'd0);

        // 3-lane build: out-of-range select, 300 discarded beats
        en3 = 1; mode3 = 0; sel3 = 2'd3; din3 = 8'hC3; rin3 = 3'b111; vin3 = 1;
        for (int i = 1; i <= 300; i++) begin
            #1;
            check("t4_ready", 64'(rout3), 64'd1);
            cycle();
            check("t4_valid", 64'(vout3), 64'd0);
            check("t4_pulse", 64'(dp3), 64'd1);
            check("t4_count", 64'(dc3), 64'((i > 255) ? 255 : i));
        end
        check("t4_data", 64'(dout3), 64'd0);
        vin3 = 0;
        cycle();
        check("t4_pulse_end", 64'(dp3), 64'd0);
        check("t4_count_end", 64'(dc3), 64'd255);

        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
